// File: rtl/tlx_fwd_sched.sv
// -----------------------------------------------------------------------------
// tlx_fwd_sched
//
// Two-source, packet-atomic, credit-gated forwarding scheduler for a link.
// Each source is granted for a whole packet.  Grants alternate round-robin:
// after a packet ends, the other source is favoured.  Beats pass through a
// single output register that sustains one beat per cycle.  One receiver
// credit is spent per forwarded beat.  Credits come back on the flow channel.
//
// Optional feature macro: TLX_FWD_SCHED_STATS_EN
//   When defined, per-source 16-bit accepted-beat counters are built.
//   When undefined, beats0/beats1 are tied to zero and no counter flops exist.
//
// Ports
//   tlx_fwd_clk              in   sole clock
//   tlx_fwd_reset            in   synchronous active-high reset
//   s0_*/s1_*                     source streams (tvalid/tready/tdata[40]/tlast)
//   tlx_fwd_payload_*             link beat stream (tvalid/tready/tdata[40])
//   tlx_fwd_flow_*                credit return (tvalid/tready=1/tdata[2])
//   credits     out  CREDIT_W  current credit count
//   credit_err  out  1         sticky credit overflow flag
//   beats0/1    out  16        per-source accepted-beat counters
// -----------------------------------------------------------------------------
module tlx_fwd_sched #(
  parameter int NUM_CREDITS = 8,
  parameter int CREDIT_W    = 4
) (
  input  logic                tlx_fwd_clk,
  input  logic                tlx_fwd_reset,

  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic [39:0]         s0_tdata,
  input  logic                s0_tlast,

  input  logic                s1_tvalid,
  output logic                s1_tready,
  input  logic [39:0]         s1_tdata,
  input  logic                s1_tlast,

  output logic                tlx_fwd_payload_tvalid,
  input  logic                tlx_fwd_payload_tready,
  output logic [39:0]         tlx_fwd_payload_tdata,

  input  logic                tlx_fwd_flow_tvalid,
  output logic                tlx_fwd_flow_tready,
  input  logic [1:0]          tlx_fwd_flow_tdata,

  output logic [CREDIT_W-1:0] credits,
  output logic                credit_err,
  output logic [15:0]         beats0,
  output logic [15:0]         beats1
);

  // The credit sum needs headroom for the largest return (3) on top of a
  // full counter, so it is evaluated two bits wider than the counter.
  localparam int SUM_W = CREDIT_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rr_ptr;
  logic                 w_rr_ptr_next;

  logic [CREDIT_W-1:0]  r_credits;
  logic                 r_credit_err;
  logic                 r_out_valid;
  logic [39:0]          r_out_data;

  logic                 w_slot_free;
  logic                 w_credit_avail;
  logic                 w_ready0;
  logic                 w_ready1;
  logic                 w_accept0;
  logic                 w_accept1;
  logic                 w_accept;
  logic [1:0]           w_ret;
  logic [SUM_W-1:0]     w_credit_sum;
  logic                 w_credit_ovf;

  // ---------------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------------
  // The output register can take a new beat when it is empty or draining.
  assign w_slot_free    = !r_out_valid || tlx_fwd_payload_tready;
  assign w_credit_avail = (r_credits != '0);

  // Reset is synchronous, so the state register may still show a grant while
  // reset is asserted; the tready terms are masked so no beat slips through.
  assign w_ready0 = (r_state == ST_GNT0) && w_slot_free && w_credit_avail && !tlx_fwd_reset;
  assign w_ready1 = (r_state == ST_GNT1) && w_slot_free && w_credit_avail && !tlx_fwd_reset;

  assign w_accept0 = s0_tvalid && w_ready0;
  assign w_accept1 = s1_tvalid && w_ready1;
  assign w_accept  = w_accept0 || w_accept1;

  assign s0_tready           = w_ready0;
  assign s1_tready           = w_ready1;
  assign tlx_fwd_flow_tready = 1'b1;

  // ---------------------------------------------------------------------------
  // Grant FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge tlx_fwd_clk) begin
    if (tlx_fwd_reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant FSM: next state
  // ---------------------------------------------------------------------------
  // IDLE only arbitrates; it never accepts.  A grant is released only by an
  // accepted tlast beat, so a credit stall or a source bubble holds the grant.
  always_comb begin
    w_state_next  = r_state;
    w_rr_ptr_next = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_credit_avail && (s0_tvalid || s1_tvalid)) begin
          // Favoured source wins if valid; otherwise the other one (which
          // must then be the valid one).
          if (r_rr_ptr ? s1_tvalid : !s0_tvalid) begin
            w_state_next = ST_GNT1;
          end else begin
            w_state_next = ST_GNT0;
          end
        end
      end
      ST_GNT0: begin
        if (w_accept0 && s0_tlast) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = 1'b1;
        end
      end
      ST_GNT1: begin
        if (w_accept1 && s1_tlast) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // Loads on acceptance; otherwise holds until the link takes the beat.
  always_ff @(posedge tlx_fwd_clk) begin
    if (tlx_fwd_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_accept1 ? s1_tdata : s0_tdata;
    end else if (tlx_fwd_payload_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign tlx_fwd_payload_tvalid = r_out_valid;
  assign tlx_fwd_payload_tdata  = r_out_data;

  // ---------------------------------------------------------------------------
  // Credit accounting
  // ---------------------------------------------------------------------------
  // Consume and return in the same cycle are both counted.  The subtraction
  // cannot underflow: a beat is only accepted while credits are non-zero.
  assign w_ret        = tlx_fwd_flow_tvalid ? tlx_fwd_flow_tdata : 2'd0;
  assign w_credit_sum = SUM_W'(r_credits) - SUM_W'(w_accept) + SUM_W'(w_ret);
  assign w_credit_ovf = (w_credit_sum > SUM_W'(NUM_CREDITS));

  always_ff @(posedge tlx_fwd_clk) begin
    if (tlx_fwd_reset) begin
      r_credits    <= CREDIT_W'(NUM_CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      if (w_credit_ovf) begin
        r_credits    <= CREDIT_W'(NUM_CREDITS);
        r_credit_err <= 1'b1;
      end else begin
        r_credits    <= w_credit_sum[CREDIT_W-1:0];
      end
    end
  end

  assign credits    = r_credits;
  assign credit_err = r_credit_err;

  // ---------------------------------------------------------------------------
  // Optional per-source beat statistics
  // ---------------------------------------------------------------------------
`ifdef TLX_FWD_SCHED_STATS_EN
  logic [1:0]  w_acc_vec;
  logic [15:0] r_beats [2];

  assign w_acc_vec = {w_accept1, w_accept0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    // Free-running 16-bit counters; wrap is intentional.
    always_ff @(posedge tlx_fwd_clk) begin
      if (tlx_fwd_reset) begin
        r_beats[gi] <= '0;
      end else if (w_acc_vec[gi]) begin
        r_beats[gi] <= r_beats[gi] + 16'd1;
      end
    end
  end

  assign beats0 = r_beats[0];
  assign beats1 = r_beats[1];
`else
  assign beats0 = '0;
  assign beats1 = '0;
`endif

endmodule

// File: tb/tb_tlx_fwd_sched.sv
// -----------------------------------------------------------------------------
// tb_tlx_fwd_sched
//
// Directed scenarios followed by randomized traffic against a transaction-level
// reference model.  The model tracks the grant owner, the favoured source, the
// credit count and a queue of beats expected on the link.  Each source
// generates packets whose beats encode {source, packet#, beat#, length}.  As a
// result, ordering and interleave errors show up as data mismatches.
// -----------------------------------------------------------------------------
module tb_tlx_fwd_sched;

  localparam int NC = 8;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_v [2];
  logic [39:0] drv_d [2];
  logic        drv_l [2];
  logic        s0_tready, s1_tready;
  logic        pay_tvalid, pay_rdy;
  logic [39:0] pay_tdata;
  logic        flow_v, flow_tready;
  logic [1:0]  flow_d;
  logic [CW-1:0] credits;
  logic        credit_err;
  logic [15:0] beats0, beats1;

  always #5 clk = ~clk;

  tlx_fwd_sched #(.NUM_CREDITS(NC), .CREDIT_W(CW)) dut (
    .tlx_fwd_clk            (clk),
    .tlx_fwd_reset          (rst),
    .s0_tvalid              (drv_v[0]),
    .s0_tready              (s0_tready),
    .s0_tdata               (drv_d[0]),
    .s0_tlast               (drv_l[0]),
    .s1_tvalid              (drv_v[1]),
    .s1_tready              (s1_tready),
    .s1_tdata               (drv_d[1]),
    .s1_tlast               (drv_l[1]),
    .tlx_fwd_payload_tvalid (pay_tvalid),
    .tlx_fwd_payload_tready (pay_rdy),
    .tlx_fwd_payload_tdata  (pay_tdata),
    .tlx_fwd_flow_tvalid    (flow_v),
    .tlx_fwd_flow_tready    (flow_tready),
    .tlx_fwd_flow_tdata     (flow_d),
    .credits                (credits),
    .credit_err             (credit_err),
    .beats0                 (beats0),
    .beats1                 (beats1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Source packet generators
  int src_pkt [2];
  int src_beat[2];
  int src_len [2];

  // Reference model
  int          m_gnt;    // -1 none, else owning source
  int          m_rr;
  int          m_cred;
  int          m_err;
  int          m_beats[2];
  logic [39:0] m_q[$];

  function automatic logic [39:0] gen_data(input int s);
    return {8'(s), 16'(src_pkt[s]), 8'(src_beat[s]), 8'(src_len[s])};
  endfunction

  task automatic src_new_packet(input int s);
    src_pkt[s]++;
    src_beat[s] = 0;
    src_len[s]  = int'($urandom_range(1, 4));
  endtask

  task automatic model_reset();
    m_gnt = -1;
    m_rr  = 0;
    m_cred = NC;
    m_err = 0;
    m_beats[0] = 0;
    m_beats[1] = 0;
    m_q.delete();
    for (int s = 0; s < 2; s++) src_new_packet(s);
  endtask

  // One clock cycle: inputs (valid/ready/flow/rst) have been set by the
  // caller at the falling edge; payload comes from the generators.
  task automatic step();
    bit exp_rdy[2];
    bit slot_free;
    int acc;
    int sum;
    int ret;
    int exp_b[2];
    for (int s = 0; s < 2; s++) begin
      drv_d[s] = gen_data(s);
      drv_l[s] = (src_beat[s] == src_len[s] - 1);
    end
    #1;
    slot_free = (m_q.size() == 0) || pay_rdy;
    for (int s = 0; s < 2; s++)
      exp_rdy[s] = !rst && (m_gnt == s) && slot_free && (m_cred > 0);
`ifdef TLX_FWD_SCHED_STATS_EN
    exp_b[0] = m_beats[0];
    exp_b[1] = m_beats[1];
`else
    exp_b[0] = 0;
    exp_b[1] = 0;
`endif
    chk("s0_tready", 64'(s0_tready), 64'(exp_rdy[0]));
    chk("s1_tready", 64'(s1_tready), 64'(exp_rdy[1]));
    chk("pay_tvalid", 64'(pay_tvalid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) chk("pay_tdata", 64'(pay_tdata), 64'(m_q[0]));
    chk("credits", 64'(credits), 64'(m_cred));
    chk("credit_err", 64'(credit_err), 64'(m_err));
    chk("flow_tready", 64'(flow_tready), 64'd1);
    chk("beats0", 64'(beats0), 64'(exp_b[0]));
    chk("beats1", 64'(beats1), 64'(exp_b[1]));

    if (rst) begin
      model_reset();
    end else begin
      acc = -1;
      for (int s = 0; s < 2; s++) if (drv_v[s] && exp_rdy[s]) acc = s;
      if (m_q.size() != 0 && pay_rdy) void'(m_q.pop_front());
      if (acc >= 0) begin
        m_q.push_back(drv_d[acc]);
        m_beats[acc] = (m_beats[acc] + 1) % 65536;
        if (drv_l[acc]) begin
          m_gnt = -1;
          m_rr  = 1 - acc;
          src_new_packet(acc);
        end else begin
          src_beat[acc]++;
        end
      end else if (m_gnt < 0 && m_cred > 0 && (drv_v[0] || drv_v[1])) begin
        m_gnt = drv_v[m_rr] ? m_rr : 1 - m_rr;
      end
      ret = flow_v ? int'(flow_d) : 0;
      sum = m_cred - ((acc >= 0) ? 1 : 0) + ret;
      if (sum > NC) begin
        m_cred = NC;
        m_err  = 1;
      end else begin
        m_cred = sum;
      end
    end
    $display("cyc v=%b%b rdy=%b%b out=%b/%h cred=%0d err=%b", drv_v[1], drv_v[0],
             s1_tready, s0_tready, pay_tvalid, pay_tdata, credits, credit_err);
    @(negedge clk);
  endtask

  task automatic rand_inputs(input int pv, input int pr, input int pf);
    for (int s = 0; s < 2; s++) drv_v[s] = ($urandom_range(99) < pv);
    pay_rdy = ($urandom_range(99) < pr);
    flow_v  = ($urandom_range(99) < pf);
    flow_d  = 2'($urandom_range(3));
  endtask

  int pv_t[4] = '{70, 90, 50, 80};
  int pr_t[4] = '{80, 100, 40, 90};
  int pf_t[4] = '{30, 10, 50, 0};

  initial begin
    rst = 1'b1;
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    drv_d[0] = '0;   drv_d[1] = '0;
    drv_l[0] = 1'b0; drv_l[1] = 1'b0;
    pay_rdy = 1'b0; flow_v = 1'b0; flow_d = 2'd0;
    src_pkt[0] = 0; src_pkt[1] = 0;
    repeat (2) @(negedge clk);
    model_reset();
    step();
    chk("rst_credits", 64'(credits), 64'(NC));
    chk("rst_tvalid", 64'(pay_tvalid), 64'd0);
    chk("rst_tdata", 64'(pay_tdata), 64'd0);
    rst = 1'b0;

    // 3-beat packet from s0, link always ready, no returns
    src_len[0] = 3;
    src_beat[0] = 0;
    drv_v[0] = 1'b1;
    pay_rdy  = 1'b1;
    repeat (4) step();
    drv_v[0] = 1'b0;
    repeat (2) step();
    chk("pkt3_credits", 64'(credits), 64'd5);

    // Drain all credits; the next beat must stall
    drv_v[0] = 1'b1;
    repeat (12) step();
    chk("drain_credits", 64'(credits), 64'd0);
    chk("drain_s0_tready", 64'(s0_tready), 64'd0);
    flow_v = 1'b1; flow_d = 2'd1;
    step();
    flow_v = 1'b0;
    repeat (3) step();

    // Both sources competing, then a link stall with a beat pending
    drv_v[1] = 1'b1;
    repeat (3) step();
    flow_v = 1'b1; flow_d = 2'd2;
    repeat (3) step();
    flow_v = 1'b0;
    pay_rdy = 1'b0;
    repeat (5) step();
    pay_rdy = 1'b1;
    repeat (8) step();

    // Overflow: returns beyond capacity saturate and set the sticky flag
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    flow_v = 1'b1; flow_d = 2'd3;
    repeat (5) step();
    flow_v = 1'b0;
    step();
    chk("ovf_credits", 64'(credits), 64'(NC));
    chk("ovf_err", 64'(credit_err), 64'd1);
    repeat (3) step();
    chk("ovf_err_sticky", 64'(credit_err), 64'd1);

    // Randomized traffic in phases, with one reset dropped in mid-traffic
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 700; c++) begin
        rand_inputs(pv_t[p], pr_t[p], pf_t[p]);
        rst = (p == 2 && c == 300);
        step();
      end
    end
    rst = 1'b0;

    // Statistics: five s1 beats after a fresh reset
    rst = 1'b1;
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    flow_v = 1'b0; pay_rdy = 1'b1;
    step();
    rst = 1'b0;
    chk("post_rst_err", 64'(credit_err), 64'd0);
    drv_v[1] = 1'b1;
    for (int c = 0; c < 60 && m_beats[1] < 5; c++) step();
    chk("stats_reached", 64'(m_beats[1]), 64'd5);
    drv_v[1] = 1'b0;
    step();
`ifdef TLX_FWD_SCHED_STATS_EN
    chk("stats_beats1", 64'(beats1), 64'd5);
`else
    chk("stats_beats1", 64'(beats1), 64'd0);
`endif
    chk("stats_beats0", 64'(beats0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
